lrn_window_buffer: RTL

- Read-side partner of the LRN mapper.
- Captures the stream of pixels returned from feature memory for one spatial position across all dim3 channels.
- Asserts full_flag once the channel vector is complete, then computes the cross-channel local sum of squares for each channel.
- Streams each (pixel, sum) pair to the divider over a valid/ready handshake and pulses normalized_window when the vector is drained, so the mapper can issue the next read burst.

---
 rtl/lrn_window_buffer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/lrn_window_buffer.sv
// Channel-vector capture buffer for LRN: stores one spatial position across all
// channels, then streams each centre pixel with its cross-channel sum of squares.
//
// state | meaning
// IDLE  | waiting for start_window
// FILL  | capturing rd_data into the channel vector until D entries are stored
// PRIME | pre-loading the sliding-window sum with the first min(H+1, D) squares
// DRAIN | presenting (pixel, sum) per channel; window slides on each handshake
module lrn_window_buffer #(
   parameter int M_WIDTH    = 10,
   parameter int DATA_WIDTH = 16,
   parameter int MAX_DEPTH  = 64,
   parameter int WIN        = 5,
   parameter int ACC_WIDTH  = 2*DATA_WIDTH + $clog2(WIN)
) (
   input  logic                  core_clk,
   input  logic                  reset_n,
   input  logic                  start_window,
   input  logic                  normalized_layer,
   input  logic [M_WIDTH-1:0]    dim3,
   input  logic                  r_enable,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  full_flag,
   output logic [DATA_WIDTH-1:0] pixel_out,
   output logic [ACC_WIDTH-1:0]  sq_sum_out,
   output logic                  sum_valid,
   input  logic                  sum_ready,
   output logic                  normalized_window
);

   localparam int H       = (WIN - 1) / 2;
   localparam int PTR_W   = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
   localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);
   localparam int IDX_W   = DEPTH_W + $clog2(WIN + 1) + 1;
   localparam int SQ_W    = 2 * DATA_WIDTH;

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_PRIME, S_DRAIN} state_t;

   state_t               state_q, state_d;
   logic                 rd_valid_q;
   logic [DEPTH_W-1:0]   depth_q, depth_d;
   logic [DEPTH_W-1:0]   wr_cnt_q, wr_cnt_d;
   logic [DEPTH_W-1:0]   p_q, p_d;
   logic [DEPTH_W-1:0]   c_q, c_d;
   logic [ACC_WIDTH-1:0] s_q, s_d;
   logic                 full_q, full_d;
   logic                 valid_q, valid_d;
   logic                 nw_q, nw_d;

   logic [DATA_WIDTH-1:0] pix_mem [MAX_DEPTH];
   logic [SQ_W-1:0]       sq_mem  [MAX_DEPTH];

   logic                 wr_en;
   logic [SQ_W-1:0]      rd_ext;
   logic [SQ_W-1:0]      rd_sq;
   logic [DEPTH_W-1:0]   dim3_clamped;
   logic [DEPTH_W-1:0]   prime_len;
   logic                 start_ok;
   logic                 handshake;
   logic                 last_ch;
   logic [PTR_W-1:0]     add_ptr, sub_ptr;
   logic [ACC_WIDTH-1:0] add_term, sub_term;

   // Square of a signed sample is non-negative and fits in 2*DATA_WIDTH bits.
   assign rd_ext = {{DATA_WIDTH{rd_data[DATA_WIDTH-1]}}, rd_data};
   assign rd_sq  = rd_ext * rd_ext;

   assign dim3_clamped = (32'(dim3) > MAX_DEPTH) ? DEPTH_W'(MAX_DEPTH) : DEPTH_W'(dim3);
   assign prime_len    = (depth_q > DEPTH_W'(H + 1)) ? DEPTH_W'(H + 1) : depth_q;
   assign start_ok     = start_window && (dim3 != '0);

   always_comb begin
      state_d   = state_q;
      depth_d   = depth_q;
      wr_cnt_d  = wr_cnt_q;
      p_d       = p_q;
      c_d       = c_q;
      s_d       = s_q;
      full_d    = full_q;
      valid_d   = valid_q;
      nw_d      = 1'b0;
      wr_en     = 1'b0;
      handshake = valid_q && sum_ready;
      last_ch   = (c_q == depth_q - 1'b1);
      add_ptr   = c_q[PTR_W-1:0] + PTR_W'(H + 1);
      sub_ptr   = c_q[PTR_W-1:0] - PTR_W'(H);
      // Sliding window: channel c+H+1 enters, channel c-H leaves.
      add_term  = ((IDX_W'(c_q) + IDX_W'(H + 1)) < IDX_W'(depth_q))
                  ? ACC_WIDTH'(sq_mem[add_ptr]) : '0;
      sub_term  = (IDX_W'(c_q) >= IDX_W'(H)) ? ACC_WIDTH'(sq_mem[sub_ptr]) : '0;

      if (normalized_layer) begin
         state_d  = S_IDLE;
         wr_cnt_d = '0;
         p_d      = '0;
         c_d      = '0;
         s_d      = '0;
         full_d   = 1'b0;
         valid_d  = 1'b0;
         nw_d     = (state_q == S_DRAIN) && handshake && last_ch;
      end else if (start_ok) begin
         state_d  = S_FILL;
         depth_d  = dim3_clamped;
         wr_cnt_d = '0;
         s_d      = '0;
         full_d   = 1'b0;
         valid_d  = 1'b0;
      end else begin
         case (state_q)
            S_FILL: begin
               if (rd_valid_q) begin
                  wr_en    = 1'b1;
                  wr_cnt_d = wr_cnt_q + 1'b1;
                  if (wr_cnt_q + 1'b1 == depth_q) begin
                     full_d  = 1'b1;
                     s_d     = '0;
                     p_d     = '0;
                     state_d = S_PRIME;
                  end
               end
            end
            S_PRIME: begin
               s_d = s_q + ACC_WIDTH'(sq_mem[p_q[PTR_W-1:0]]);
               p_d = p_q + 1'b1;
               if (p_q + 1'b1 == prime_len) begin
                  c_d     = '0;
                  valid_d = 1'b1;
                  state_d = S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (handshake) begin
                  s_d = s_q + add_term - sub_term;
                  c_d = c_q + 1'b1;
                  if (last_ch) begin
                     valid_d  = 1'b0;
                     full_d   = 1'b0;
                     nw_d     = 1'b1;
                     wr_cnt_d = '0;
                     state_d  = S_FILL;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge core_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         rd_valid_q <= 1'b0;
         depth_q    <= '0;
         wr_cnt_q   <= '0;
         p_q        <= '0;
         c_q        <= '0;
         s_q        <= '0;
         full_q     <= 1'b0;
         valid_q    <= 1'b0;
         nw_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_valid_q <= r_enable;
         depth_q    <= depth_d;
         wr_cnt_q   <= wr_cnt_d;
         p_q        <= p_d;
         c_q        <= c_d;
         s_q        <= s_d;
         full_q     <= full_d;
         valid_q    <= valid_d;
         nw_q       <= nw_d;
      end
   end

   // Vector storage carries no reset; contents are rewritten before every use.
   always_ff @(posedge core_clk) begin
      if (wr_en) begin
         pix_mem[wr_cnt_q[PTR_W-1:0]] <= rd_data;
         sq_mem[wr_cnt_q[PTR_W-1:0]]  <= rd_sq;
      end
   end

   assign full_flag         = full_q;
   assign sum_valid         = valid_q;
   assign normalized_window = nw_q;
   assign pixel_out         = valid_q ? pix_mem[c_q[PTR_W-1:0]] : '0;
   assign sq_sum_out        = valid_q ? s_q : '0;

endmodule
